banco_registros_param: RTL

Parametrised successor to the single-write, two-read register bank for the RISC-V micro. Width, depth and read-port count are configurable. A second write port carries load-return data, with optional write-to-read bypass. A per-register pending scoreboard flags sources awaiting an outstanding load. It sits between decode (reads, pending set), the ALU writeback (port A) and the memory return path (port B).

---
 rtl/banco_registros_param.sv | 126 ++++++++++++
 1 files changed

// File: rtl/banco_registros_param.sv
// Parametrised RISC-V register bank: NREAD combinational read ports, ALU and load-return
// write ports, optional write-to-read bypass and a per-register load-pending scoreboard.

module banco_rd_port #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic [AW-1:0]                addr,
    input  logic [DEPTH-1:0][WIDTH-1:0]  regs,
    input  logic [DEPTH-1:0]             pending,
    input  logic                         byp_en,
    input  logic                         wr_a_en,
    input  logic [AW-1:0]                wr_a_reg,
    input  logic [WIDTH-1:0]             wr_a_data,
    input  logic                         wr_b_en,
    input  logic [AW-1:0]                wr_b_reg,
    input  logic [WIDTH-1:0]             wr_b_data,
    output logic [WIDTH-1:0]             data,
    output logic                         busy
);
    logic a_hit, b_hit, use_byp;

    // Bypass is held off during reset so reads stay at zero while RST_n is low.
    assign use_byp = (BYPASS != 0) && byp_en;
    assign a_hit   = use_byp && wr_a_en && (wr_a_reg == addr);
    assign b_hit   = use_byp && wr_b_en && (wr_b_reg == addr);

    always_comb begin
        data = regs[addr];
        if (addr == '0)
            data = '0;
        else if (a_hit)
            data = wr_a_data;
        else if (b_hit)
            data = wr_b_data;
    end

    // A load returning this cycle already carries the value, so it is not reported busy.
    assign busy = (addr != '0) && pending[addr] && !b_hit;
endmodule

module banco_registros_param #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    input  logic [NREAD*AW-1:0]     readReg,
    output logic [NREAD*WIDTH-1:0]  readData,
    output logic [NREAD-1:0]        readBusy,
    input  logic [AW-1:0]           writeReg,
    input  logic [WIDTH-1:0]        writeData,
    input  logic                    RegWrite,
    input  logic [AW-1:0]           ldReg,
    input  logic [WIDTH-1:0]        ldData,
    input  logic                    ldWrite,
    input  logic                    pendSet,
    input  logic [AW-1:0]           pendReg,
    output logic                    wrCollision
);
    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            pending;
    logic                        a_en, b_en, same_dst;

    assign same_dst = (writeReg == ldReg);
    assign a_en     = RegWrite && (writeReg != '0);
    // Port A owns the register when both ports target it; port B data is dropped.
    assign b_en     = ldWrite && (ldReg != '0) && !(a_en && same_dst);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            regs <= '0;
        end else begin
            if (b_en)
                regs[ldReg] <= ldData;
            if (a_en)
                regs[writeReg] <= writeData;
        end
    end

    // Set is applied after clear so a reissued load keeps the bit high.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            pending <= '0;
        end else begin
            if (ldWrite && (ldReg != '0))
                pending[ldReg] <= 1'b0;
            if (pendSet && (pendReg != '0))
                pending[pendReg] <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            wrCollision <= 1'b0;
        else
            wrCollision <= RegWrite && ldWrite && same_dst && (writeReg != '0);
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        banco_rd_port #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .BYPASS (BYPASS),
            .AW     (AW)
        ) u_port (
            .addr      (readReg[i*AW +: AW]),
            .regs      (regs),
            .pending   (pending),
            .byp_en    (RST_n),
            .wr_a_en   (RegWrite),
            .wr_a_reg  (writeReg),
            .wr_a_data (writeData),
            .wr_b_en   (ldWrite),
            .wr_b_reg  (ldReg),
            .wr_b_data (ldData),
            .data      (readData[i*WIDTH +: WIDTH]),
            .busy      (readBusy[i])
        );
    end
endmodule
